// File: rtl/fft_bitrev_reorder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fft_bitrev_reorder                                           |
// | Description : Ping-pong reorder buffer that turns the bit-reversed SDF FFT |
// |               output stream into natural-order contiguous bursts.          |
// |               Optional error pulse output via macro FFT_REORDER_ERR_EN.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fft_bitrev_reorder #(
    parameter int DATA_WIDTH = 16,
    parameter int FFT_N      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sig_start_i,
    input  logic                  sig_vld_i,
    input  logic [DATA_WIDTH-1:0] sig_real_i,
    input  logic [DATA_WIDTH-1:0] sig_imag_i,
    output logic                  sig_start_o,
    output logic                  sig_vld_o,
    output logic [DATA_WIDTH-1:0] sig_real_o,
    output logic [DATA_WIDTH-1:0] sig_imag_o
`ifdef FFT_REORDER_ERR_EN
    ,
    output logic                  err_o
`endif
);

    localparam logic [ADDR_WIDTH-1:0] c_LAST_IDX = ADDR_WIDTH'(FFT_N - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ONE      = ADDR_WIDTH'(1);

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_FILL = 1'b1} wstate_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DRAIN = 1'b1} rstate_t;

    function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] x);
        logic [ADDR_WIDTH-1:0] r;
        for (int b = 0; b < ADDR_WIDTH; b++) begin
            r[b] = x[ADDR_WIDTH-1-b];
        end
        return r;
    endfunction

    logic [2*DATA_WIDTH-1:0] r_mem [0:2*FFT_N-1];

    wstate_t               r_wstate;
    rstate_t               r_rstate;
    logic [ADDR_WIDTH-1:0] r_wr_cnt;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_wr_bank;
    logic                  r_rd_bank;
    logic [1:0]            r_full;

    logic                  w_wr_en;
    logic                  w_wr_done;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic                  w_rd_en;
    logic                  w_rd_last;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [2*DATA_WIDTH-1:0] w_rd_word;

    // A start always lands at index 0 (bitrev(0) = 0), restarting any partial frame.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_done = 1'b0;
        w_wr_addr = '0;
        if (sig_vld_i) begin
            if (sig_start_i) begin
                w_wr_en = !r_full[r_wr_bank];
            end else if (r_wstate == W_FILL) begin
                w_wr_en   = 1'b1;
                w_wr_addr = bitrev(r_wr_cnt);
                w_wr_done = (r_wr_cnt == c_LAST_IDX);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[{r_wr_bank, w_wr_addr}] <= {sig_real_i, sig_imag_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate  <= W_IDLE;
            r_wr_cnt  <= '0;
            r_wr_bank <= 1'b0;
        end else if (sig_vld_i) begin
            if (sig_start_i) begin
                if (!r_full[r_wr_bank]) begin
                    r_wstate <= W_FILL;
                    r_wr_cnt <= c_ONE;
                end
            end else if (r_wstate == W_FILL) begin
                if (w_wr_done) begin
                    r_wstate  <= W_IDLE;
                    r_wr_cnt  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_cnt <= r_wr_cnt + c_ONE;
                end
            end
        end
    end

    // Address 0 is issued straight from idle so the first sample leaves two cycles
    // after the frame completes and consecutive frames drain without a bubble.
    always_comb begin
        w_rd_en   = (r_rstate == R_DRAIN) || r_full[r_rd_bank];
        w_rd_addr = (r_rstate == R_DRAIN) ? r_rd_addr : '0;
        w_rd_last = w_rd_en && (w_rd_addr == c_LAST_IDX);
        w_rd_word = r_mem[{r_rd_bank, w_rd_addr}];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate  <= R_IDLE;
            r_rd_addr <= '0;
            r_rd_bank <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (r_full[r_rd_bank]) begin
                        r_rstate  <= R_DRAIN;
                        r_rd_addr <= c_ONE;
                    end
                end
                R_DRAIN: begin
                    if (r_rd_addr == c_LAST_IDX) begin
                        r_rstate  <= R_IDLE;
                        r_rd_addr <= '0;
                        r_rd_bank <= ~r_rd_bank;
                    end else begin
                        r_rd_addr <= r_rd_addr + c_ONE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // Set and clear never target the same bank: only empty banks fill, only full ones drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 2'b00;
        end else begin
            if (w_wr_done) begin
                r_full[r_wr_bank] <= 1'b1;
            end
            if (w_rd_last) begin
                r_full[r_rd_bank] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_start_o <= 1'b0;
            sig_vld_o   <= 1'b0;
            sig_real_o  <= '0;
            sig_imag_o  <= '0;
        end else begin
            sig_vld_o   <= w_rd_en;
            sig_start_o <= w_rd_en && (w_rd_addr == '0);
            sig_real_o  <= w_rd_en ? w_rd_word[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
            sig_imag_o  <= w_rd_en ? w_rd_word[DATA_WIDTH-1:0] : '0;
        end
    end

`ifdef FFT_REORDER_ERR_EN
    logic w_err;

    // Flags dropped frames, abandoned partial frames and samples arriving outside a frame.
    assign w_err = sig_vld_i && (sig_start_i ? ((r_wstate == W_FILL) || r_full[r_wr_bank])
                                             : (r_wstate == W_IDLE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_o <= 1'b0;
        end else begin
            err_o <= w_err;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_reorder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fft_bitrev_reorder                                        |
// | Description : Scoreboard testbench for the bit-reversal reorder buffer.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fft_bitrev_reorder;

    localparam int DW = 16;
    localparam int N  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sig_start_i;
    logic          sig_vld_i;
    logic [DW-1:0] sig_real_i;
    logic [DW-1:0] sig_imag_i;
    logic          sig_start_o;
    logic          sig_vld_o;
    logic [DW-1:0] sig_real_o;
    logic [DW-1:0] sig_imag_o;
`ifdef FFT_REORDER_ERR_EN
    logic          err_o;
`endif

    fft_bitrev_reorder #(
        .DATA_WIDTH (DW),
        .FFT_N      (N),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sig_start_i (sig_start_i),
        .sig_vld_i   (sig_vld_i),
        .sig_real_i  (sig_real_i),
        .sig_imag_i  (sig_imag_i),
        .sig_start_o (sig_start_o),
        .sig_vld_o   (sig_vld_o),
        .sig_real_o  (sig_real_o),
        .sig_imag_o  (sig_imag_o)
`ifdef FFT_REORDER_ERR_EN
        ,
        .err_o       (err_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int            c;
        logic          st;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   n_out    = 0;
    int   cyc      = 0;
    int   err_seen = 0;
    // Natural output position j carries input index perm[j] for N=16.
    int   perm[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        checks++;
        if (sig_vld_o === 1'b1) begin
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out cyc=%0d got re=%0h im=%0h st=%0b, required no output",
                         cyc, sig_real_o, sig_imag_o, sig_start_o);
            end else begin
                mon_e = q.pop_front();
                n_out++;
                if (cyc !== mon_e.c || sig_start_o !== mon_e.st ||
                    sig_real_o !== mon_e.re || sig_imag_o !== mon_e.im) begin
                    failures++;
                    $display("FAIL out_sample got cyc=%0d st=%0b re=%0h im=%0h, required cyc=%0d st=%0b re=%0h im=%0h",
                             cyc, sig_start_o, sig_real_o, sig_imag_o,
                             mon_e.c, mon_e.st, mon_e.re, mon_e.im);
                end
            end
        end else if (sig_vld_o !== 1'b0 || sig_start_o !== 1'b0 ||
                     sig_real_o !== '0 || sig_imag_o !== '0) begin
            failures++;
            $display("FAIL idle_outputs got vld=%0b st=%0b re=%0h im=%0h, required all 0",
                     sig_vld_o, sig_start_o, sig_real_o, sig_imag_o);
        end
`ifdef FFT_REORDER_ERR_EN
        if (err_o === 1'b1) err_seen++;
`endif
    end

    task automatic send(input logic st, input logic [DW-1:0] re, input logic [DW-1:0] im);
        @(posedge clk);
        #1;
        sig_start_i = st;
        sig_vld_i   = 1'b1;
        sig_real_i  = re;
        sig_imag_i  = im;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            sig_start_i = 1'b0;
            sig_vld_i   = 1'b0;
            sig_real_i  = '0;
            sig_imag_i  = '0;
        end
    endtask

    // Drives one frame (input index i carries base+i / -(base+i)) and queues its natural-order output.
    task automatic send_frame(input int base, input int gap);
        logic [DW-1:0] re[16];
        logic [DW-1:0] im[16];
        int k;
        k = 0;
        for (int i = 0; i < N; i++) begin
            re[i] = DW'(base + i);
            im[i] = -re[i];
            send(i == 0, re[i], im[i]);
            if (i == N - 1) k = cyc;
            else idle(gap);
        end
        for (int j = 0; j < N; j++) begin
            q.push_back(exp_t'{c: k + 2 + j, st: (j == 0), re: re[perm[j]], im: im[perm[j]]});
        end
        idle(gap);
    endtask

    task automatic wait_empty(output int left);
        for (int t = 0; t < 300 && q.size() != 0; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        left = q.size();
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        sig_start_i = 1'b0;
        sig_vld_i   = 1'b0;
        sig_real_i  = '0;
        sig_imag_i  = '0;
        #1;
        checks++;
        if (sig_vld_o !== 1'b0 || sig_start_o !== 1'b0 || sig_real_o !== '0 || sig_imag_o !== '0) begin
            failures++;
            $display("FAIL reset_outputs got vld=%0b st=%0b re=%0h im=%0h, required all 0",
                     sig_vld_o, sig_start_o, sig_real_o, sig_imag_o);
        end
`ifdef FFT_REORDER_ERR_EN
        checks++;
        if (err_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_err got %0b required 0", err_o);
        end
`endif
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int left;
        send_frame(0, 0);
        idle(1);
        wait_empty(left);
        checks++;
        if (left !== 0) begin
            failures++;
            $display("FAIL single_drain got %0d pending required 0", left);
        end
    endtask

    task automatic test_gap();
        int left;
        send_frame(0, 1);
        idle(1);
        wait_empty(left);
        checks++;
        if (left !== 0) begin
            failures++;
            $display("FAIL gap_drain got %0d pending required 0", left);
        end
    endtask

    task automatic test_back_to_back();
        int left;
        send_frame(0, 0);
        send_frame(16, 0);
        send_frame(32, 0);
        idle(1);
        wait_empty(left);
        checks++;
        if (left !== 0) begin
            failures++;
            $display("FAIL b2b_drain got %0d pending required 0", left);
        end
    endtask

    task automatic test_abandon();
        int left;
        int e0;
        e0 = err_seen;
        send(1'b1, 16'd0, 16'd0);
        for (int i = 1; i < 5; i++) send(1'b0, DW'(i), -DW'(i));
        send_frame(100, 0);
        idle(1);
        wait_empty(left);
        checks++;
        if (left !== 0) begin
            failures++;
            $display("FAIL abandon_drain got %0d pending required 0", left);
        end
`ifdef FFT_REORDER_ERR_EN
        checks++;
        if (err_seen - e0 !== 1) begin
            failures++;
            $display("FAIL abandon_err got %0d pulses required 1", err_seen - e0);
        end
`endif
    endtask

    task automatic test_discard();
        int left;
        int e0;
        e0 = err_seen;
        for (int i = 0; i < 3; i++) send(1'b0, DW'(500 + i), DW'(600 + i));
        send_frame(200, 0);
        idle(1);
        wait_empty(left);
        checks++;
        if (left !== 0) begin
            failures++;
            $display("FAIL discard_drain got %0d pending required 0", left);
        end
`ifdef FFT_REORDER_ERR_EN
        checks++;
        if (err_seen - e0 !== 3) begin
            failures++;
            $display("FAIL discard_err got %0d pulses required 3", err_seen - e0);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int left;
        int target;
        bit hit;
        hit    = 1'b0;
        target = n_out + 8;
        send_frame(300, 0);
        idle(1);
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            #1;
            if (n_out >= target) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL mid_reach got %0d samples required %0d", n_out, target);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sig_vld_o !== 1'b0 || sig_start_o !== 1'b0 || sig_real_o !== '0 || sig_imag_o !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs got vld=%0b st=%0b re=%0h im=%0h, required all 0",
                     sig_vld_o, sig_start_o, sig_real_o, sig_imag_o);
        end
        q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        send_frame(400, 0);
        idle(1);
        wait_empty(left);
        checks++;
        if (left !== 0) begin
            failures++;
            $display("FAIL post_reset_drain got %0d pending required 0", left);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_gap();
        test_back_to_back();
        test_abandon();
        test_discard();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
Sink-side reorder buffer at the end of the SDF FFT stage chain. It takes the last stage's sample stream (sig_start/sig_vld/real/imag), which arrives in bit-reversed order. It writes each frame into one bank of an internal ping-pong buffer at the bit-reversed address. It then drains the frame in natural order as a contiguous burst, using the same start/vld stream protocol on its output.

Parameters:
DATA_WIDTH, 16, width of real and of imag
FFT_N, 16, samples per frame; power of 2, at least 4
ADDR_WIDTH, 4, log2(FFT_N); full frame index width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active-low
sig_start_i  input  1  first sample of a frame; qualified with sig_vld_i
sig_vld_i  input  1  input sample valid; gaps allowed
sig_real_i  input  DATA_WIDTH  input real part
sig_imag_i  input  DATA_WIDTH  input imag part
sig_start_o  output  1  one-cycle pulse coincident with output sample 0
sig_vld_o  output  1  output sample valid
sig_real_o  output  DATA_WIDTH  output real part, natural order
sig_imag_o  output  DATA_WIDTH  output imag part, natural order

Behaviour:
- Reset: all outputs 0; both banks empty; wr_bank=0, rd_bank=0; write FSM W_IDLE; read FSM R_IDLE. Buffer contents are not reset.
- Storage: 2 banks x FFT_N x (2*DATA_WIDTH). Registered read. No backpressure on either side.
- Write FSM:
  - W_IDLE: samples with sig_vld_i=1, sig_start_i=0 are discarded.
  - On sig_vld_i & sig_start_i: if bank wr_bank is empty, store the sample at addr bitrev(0)=0, set wr_cnt=1, go to W_FILL. If wr_bank is full, drop the whole frame (stay W_IDLE).
  - W_FILL: each sig_vld_i stores the sample at bitrev(wr_cnt), then wr_cnt++.
  - Storing sample FFT_N-1 marks the bank full, toggles wr_bank, returns to W_IDLE.
  - sig_start_i while in W_FILL: the partial frame is abandoned and the new frame restarts at index 0 in the same bank.
  - sig_start_i without sig_vld_i is ignored.
- bitrev(x) reverses all ADDR_WIDTH bits; e.g. N=16: 1->8, 3->12.
- Read FSM:
  - R_IDLE: when bank rd_bank is full, go to R_DRAIN with rd_addr=0.
  - R_DRAIN: issue one read per cycle, addresses 0..FFT_N-1. After the last address is issued, mark the bank empty and toggle rd_bank.
  - If the other bank is already full at that moment, continue directly into its drain with no idle cycle (back-to-back frames).
- Latency: last input sample of a frame presented in cycle k. Output sample 0 appears in cycle k+2 with sig_start_o=1. Output sample j appears in cycle k+2+j; sig_vld_o stays high for exactly FFT_N contiguous cycles.
- Outputs are registered. When sig_vld_o=0, sig_real_o/sig_imag_o are driven 0.
- Rate: input at most 1 sample/cycle and drain exactly 1/cycle, so the drop condition is unreachable for conforming upstream. It is still required to be safe.
- Same-cycle write and read of the same bank: impossible by construction, since a bank is read only when full and written only when empty.
- Reset mid-operation: asynchronous clear to the reset state; any frame in flight is lost.

Optional Feature:
Macro FFT_REORDER_ERR_EN.
- Defined: adds output err_o (1 bit, reset 0), a registered one-cycle pulse on:
  - a frame dropped because the target bank is full;
  - a partial frame abandoned by sig_start_i in W_FILL;
  - sig_vld_i discarded in W_IDLE.
- Undefined: no err_o port. The data path behaves identically, with drops silent.

Test Plan:
- Single frame, N=16, contiguous, real=i, imag=-i for input index i -> from cycle k+2: real = 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 (imag negated); sig_start_o pulses only on the first; sig_vld_o high exactly 16 cycles.
- Same frame with a 1-cycle gap after every input sample -> identical output sequence, contiguous, starting 2 cycles after the last input.
- Three frames back-to-back with no gaps (48 consecutive sig_vld_i) -> 48 contiguous output samples with 3 start pulses, 16 cycles apart; banks alternate 0,1,0.
- Start at input 0, 5 samples, then a new sig_start_i with a full frame of real=100+i -> output only the second frame, reordered; with FFT_REORDER_ERR_EN, err_o pulses once.
- sig_vld_i=1 with no prior start (3 samples), then a normal frame -> the 3 samples never appear; output equals the normal frame only.
- Assert rst_n low during the drain of sample 7 -> outputs go 0 immediately. A subsequent fresh frame produces correct output with start aligned to its sample 0.
